// File: rtl/hazard_ctl_unit.sv
// Load-use / taken-branch hazard controller for the MIPS32 ID stage.
// Optional saturating statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctl_unit #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int BR_FLUSH   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] src1_id,
    input  logic [REG_AW-1:0] src2_id,
    input  logic              src1_used,
    input  logic              src2_used,
    input  logic [REG_AW-1:0] dest_exe,
    input  logic              mem_read_idex,
    input  logic              branch,
    input  logic              branch_yes,
    output logic              ld_hazard_a,
    output logic              ld_hazard_b,
    output logic              hold,
    output logic              flush,
    output logic              hazard,
    output logic              busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LS_REM = 4'(LOAD_STALL - 1);
    localparam logic [3:0] BF_REM = 4'(BR_FLUSH - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  rem_r;
    logic [3:0]  rem_s;
    logic        match_a_s;
    logic        match_b_s;
    logic        take_s;
    logic        hold_s;
    logic        flush_s;
    logic        hz_a_s;
    logic        hz_b_s;

    assign match_a_s = mem_read_idex & src1_used & (src1_id == dest_exe) & (dest_exe != '0);
    assign match_b_s = mem_read_idex & src2_used & (src2_id == dest_exe) & (dest_exe != '0);
    assign take_s    = branch & branch_yes;

    // State and remaining-cycle register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rem_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
        end
    end

    // Next-state and hazard decisions; a taken branch always outranks a stall
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        hold_s  = 1'b0;
        flush_s = 1'b0;
        hz_a_s  = 1'b0;
        hz_b_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    flush_s = 1'b1;
                    if (BR_FLUSH > 1) begin
                        state_s = ST_BR_FLUSH;
                        rem_s   = BF_REM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (match_a_s || match_b_s) begin
                    hold_s = 1'b1;
                    hz_a_s = match_a_s;
                    hz_b_s = match_b_s;
                    if (LOAD_STALL > 1) begin
                        state_s = ST_LD_STALL;
                        rem_s   = LS_REM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LD_STALL: begin
                if (take_s) begin
                    flush_s = 1'b1;
                    if (BR_FLUSH > 1) begin
                        state_s = ST_BR_FLUSH;
                        rem_s   = BF_REM;
                    end else begin
                        state_s = ST_IDLE;
                        rem_s   = 4'd0;
                    end
                end else begin
                    // EXE holds a bubble now, so the match flags stay low
                    hold_s = 1'b1;
                    if (rem_r <= 4'd1) begin
                        state_s = ST_IDLE;
                        rem_s   = 4'd0;
                    end else begin
                        rem_s = rem_r - 4'd1;
                    end
                end
            end
            ST_BR_FLUSH: begin
                flush_s = 1'b1;
                if (rem_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    rem_s   = 4'd0;
                end else begin
                    rem_s = rem_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                rem_s   = 4'd0;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted
    assign hold        = hold_s & rst_n;
    assign flush       = flush_s & rst_n;
    assign ld_hazard_a = hz_a_s & rst_n;
    assign ld_hazard_b = hz_b_s & rst_n;
    assign hazard      = (hold_s | flush_s) & rst_n;
    assign busy        = (state_r != ST_IDLE) & rst_n;

`ifdef HAZARD_STATS_EN
    // Saturating hold/flush cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_s && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_s && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctl_unit.sv
// Self-checking bench: three hazard_ctl_unit configurations driven in parallel
// and compared each cycle against a remaining-cycles reference model.
module tb_hazard_ctl_unit;

    localparam int N = 3;
    localparam int LS_T [N] = '{1, 3, 4};
    localparam int BF_T [N] = '{1, 2, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] src1_id = 5'd0, src2_id = 5'd0, dest_exe = 5'd0;
    logic       src1_used = 1'b0, src2_used = 1'b0;
    logic       mem_read_idex = 1'b0, branch = 1'b0, branch_yes = 1'b0;

    // {ld_hazard_a, ld_hazard_b, hold, flush, hazard, busy}
    logic [5:0]  obs [N];
    logic [15:0] scnt [N];
    logic [15:0] fcnt [N];

    int hl [N], fl [N], nh [N], nf [N], sc [N], fc [N];
    logic [5:0] exp_v [N];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            logic ha, hb, ho, fo, hz, bz;
            hazard_ctl_unit #(
                .REG_AW(5), .LOAD_STALL(LS_T[g]), .BR_FLUSH(BF_T[g]), .CNT_W(16)
            ) u_dut (
                .clk(clk), .rst_n(rst_n),
                .src1_id(src1_id), .src2_id(src2_id),
                .src1_used(src1_used), .src2_used(src2_used),
                .dest_exe(dest_exe), .mem_read_idex(mem_read_idex),
                .branch(branch), .branch_yes(branch_yes),
                .ld_hazard_a(ha), .ld_hazard_b(hb),
                .hold(ho), .flush(fo), .hazard(hz), .busy(bz)
`ifdef HAZARD_STATS_EN
                , .stall_cnt(scnt[g]), .flush_cnt(fcnt[g])
`endif
            );
            assign obs[g] = {ha, hb, ho, fo, hz, bz};
`ifndef HAZARD_STATS_EN
            assign scnt[g] = 16'd0;
            assign fcnt[g] = 16'd0;
`endif
        end
    endgenerate

    // Apply inputs (called at the falling edge), then derive expected outputs
    task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic u1,
                         input logic u2, input logic [4:0] d, input logic mr,
                         input logic br, input logic by);
        logic ma, mb, tk, h, f, a, b, bs;
        src1_id = s1; src2_id = s2; src1_used = u1; src2_used = u2;
        dest_exe = d; mem_read_idex = mr; branch = br; branch_yes = by;
        #1;
        ma = mr && u1 && (s1 == d) && (d != 5'd0);
        mb = mr && u2 && (s2 == d) && (d != 5'd0);
        tk = br && by;
        for (int i = 0; i < N; i++) begin
            h = 1'b0; f = 1'b0; a = 1'b0; b = 1'b0;
            bs = (hl[i] > 0) || (fl[i] > 0);
            nh[i] = hl[i]; nf[i] = fl[i];
            if (!rst_n) begin
                bs = 1'b0; nh[i] = 0; nf[i] = 0;
            end else if (fl[i] > 0) begin
                f = 1'b1; nf[i] = fl[i] - 1;
            end else if (hl[i] > 0) begin
                if (tk) begin
                    f = 1'b1; nh[i] = 0; nf[i] = BF_T[i] - 1;
                end else begin
                    h = 1'b1; nh[i] = hl[i] - 1;
                end
            end else if (tk) begin
                f = 1'b1; nf[i] = BF_T[i] - 1;
            end else if (ma || mb) begin
                h = 1'b1; a = ma; b = mb; nh[i] = LS_T[i] - 1;
            end
            exp_v[i] = {a, b, h, f, h | f, bs};
        end
    endtask

    // Advance one clock and commit the model state
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                hl[i] = 0; fl[i] = 0; sc[i] = 0; fc[i] = 0;
            end else begin
                hl[i] = nh[i]; fl[i] = nf[i];
                if (exp_v[i][3] && sc[i] < 65535) sc[i]++;
                if (exp_v[i][2] && fc[i] < 65535) fc[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, c == 1, 1'b1);
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== 6'd0) begin
                    miscompares++;
                    $display("FAIL reset inst%0d cyc%0d: got %b want %b", i, c, obs[i], 6'd0);
                end
`ifdef HAZARD_STATS_EN
                vectors++;
                if (scnt[i] !== 16'd0 || fcnt[i] !== 16'd0) begin
                    miscompares++;
                    $display("FAIL reset_cnt inst%0d: got %0d/%0d want 0/0", i, scnt[i], fcnt[i]);
                end
`endif
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_stall();
        for (int c = 0; c < 12; c++) begin
            if (c < 4)       drive(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
            else if (c < 6)  drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            else if (c == 6) drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
            else             drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL load_stall inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_hazard();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
                1:       drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
                2:       drive(5'd2, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
                default: drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
            endcase
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i][3:1] !== 3'b000 || obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL no_hazard inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
            else if (c == 4) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            else if (c == 6) drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
            else if (c == 7) drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
            else             drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL branch inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_abort();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
            else if (c == 1) drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
            else             drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL branch_abort inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 12; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 3) rst_n = 1'b1;
            if (c < 3 || c == 5) drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
            else                 drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL reset_mid inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
            end
            tick();
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if (scnt[1] !== 16'd3) begin
            miscompares++;
            $display("FAIL reset_mid_cnt inst1: got %0d want 3", scnt[1]);
        end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (obs[i] !== exp_v[i]) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", i, c, obs[i], exp_v[i]);
                end
`ifdef HAZARD_STATS_EN
                vectors++;
                if (scnt[i] !== 16'(rst_n ? sc[i] : 0) || fcnt[i] !== 16'(rst_n ? fc[i] : 0)) begin
                    miscompares++;
                    $display("FAIL random_cnt inst%0d cyc%0d: got %0d/%0d want %0d/%0d",
                             i, c, scnt[i], fcnt[i], rst_n ? sc[i] : 0, rst_n ? fc[i] : 0);
                end
`endif
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            hl[i] = 0; fl[i] = 0; sc[i] = 0; fc[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_load_stall();
        test_no_hazard();
        test_branch();
        test_branch_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctl_unit.md
# hazard_ctl_unit

Parametrised pipeline hazard controller for the MIPS32 pipeline, placed alongside the ID stage. It detects load-use hazards against the instruction in EXE and holds IF/ID for a configurable number of stall cycles, supporting multi-cycle data memory. It flushes IF/ID for a configurable number of cycles after a taken branch. A small state machine sequences both cases, with defined priority when they collide.

## Interface
- REG_AW, 5: register-address width.
- LOAD_STALL, 1: stall cycles per load-use hazard (1..15).
- BR_FLUSH, 1: flush cycles per taken branch (1..15).
- CNT_W, 16: width of statistics counters (see Configuration).

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src1_id, src2_id  in  REG_AW  ID-stage source registers.
- src1_used, src2_used  in  1  source is actually read by the ID instruction.
- dest_exe  in  REG_AW  EXE-stage destination register.
- mem_read_idex  in  1  EXE instruction is a load.
- branch  in  1  EXE instruction is a branch.
- branch_yes  in  1  branch condition resolved taken.
- ld_hazard_a, ld_hazard_b  out  1  load-use match on src1 or src2, qualified by detection (see Operation).
- hold  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
- flush  out  1  squash IF/ID contents.
- hazard  out  1  hold | flush.
- busy  out  1  FSM not in IDLE.
- stall_cnt, flush_cnt  out  CNT_W  statistics (present only with HAZARD_STATS_EN).

## Operation
- Match condition for src *k*: mem_read_idex & src*k*_used & (src*k*_id == dest_exe) & (dest_exe != 0).
- FSM states: IDLE, LD_STALL, BR_FLUSH. A 4-bit down-counter `rem` holds the remaining cycles.
- **IDLE:**
  - If branch & branch_yes: flush=1 this cycle. If BR_FLUSH>1, go to BR_FLUSH with rem=BR_FLUSH-1.
  - Otherwise, if any match: hold=1 and ld_hazard_a/b reflect the matches this cycle. If LOAD_STALL>1, go to LD_STALL with rem=LOAD_STALL-1.
- **LD_STALL:**
  - hold=1. ld_hazard_a/b=0, because EXE now holds a bubble.
  - New matches are ignored.
  - rem decrements each cycle. Return to IDLE when rem reaches 1.
- **BR_FLUSH:**
  - flush=1, hold=0.
  - rem decrements each cycle. Return to IDLE when rem reaches 1.
- Priority: a taken branch beats a load-use match in the same cycle. In LD_STALL, branch & branch_yes aborts the stall: flush=1, hold=0, and the FSM enters BR_FLUSH with rem=BR_FLUSH-1, or IDLE if BR_FLUSH=1.
- A not-taken branch has no effect.
- hold and flush are never both 1.

## Timing
- Detection is combinational. hold/flush assert in the same cycle as the triggering inputs.
- A load-use hazard gives exactly LOAD_STALL consecutive hold cycles.
- A taken branch gives exactly BR_FLUSH consecutive flush cycles.
- Sequencing cycles after the first come from registered state. They do not depend on inputs, except for the branch abort.
- The next detection is evaluated in the first IDLE cycle after a sequence.
- Reset:
  - rst_n low forces IDLE, rem=0, and all outputs 0 (including the combinational ones), regardless of inputs.
  - Deassertion mid-sequence resumes in IDLE. The interrupted sequence is discarded.

## Configuration
- Macro: HAZARD_STATS_EN.
- **Defined:**
  - stall_cnt increments on every cycle with hold=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones and reset to 0.
- **Undefined:** the stall_cnt/flush_cnt ports and their logic are absent. All other behaviour is identical.

## Test plan
- LOAD_STALL=1: load to $8 in EXE, ID reads src1=$8 with src1_used=1 -> hold=1, ld_hazard_a=1 for 1 cycle; next cycle hold=0.
- LOAD_STALL=3, match on src2=$5 -> hold=1 for 3 consecutive cycles; ld_hazard_b=1 on the first cycle only; busy=1 on cycles 2-3.
- Load to $0 with src1=$0, or a match with src*_used=0 -> hold=0, hazard=0.
- BR_FLUSH=2: branch=1, branch_yes=1 -> flush=1 for 2 cycles, hold=0. With branch=1, branch_yes=0 -> no flush.
- LOAD_STALL=4, taken branch in the 2nd stall cycle -> hold drops that cycle, flush=1 for BR_FLUSH cycles, then IDLE.
- rst_n pulsed low during cycle 2 of a 3-cycle stall -> outputs 0 immediately; after release, IDLE with no residual hold. With HAZARD_STATS_EN defined, stall_cnt=0 after reset and then counts 3 for a fresh 3-cycle stall.
